// File: rtl/smem_bck_stage2.sv
// SMEM backward-extension stage 2: advances the inner j loop, rolls the outer
// i iteration, or ends the read with a one-cycle done report.
module smem_bck_stage2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [5:0]  status_q,
    input  logic [8:0]  read_num_q,
    input  logic [63:0] primary_q,
    input  logic [6:0]  new_size_q,
    input  logic [6:0]  new_last_size_q,
    input  logic [6:0]  forward_size_n_q,
    input  logic [6:0]  backward_i_q,
    input  logic [6:0]  backward_j_q,
    input  logic [6:0]  current_wr_addr_q,
    input  logic [6:0]  current_rd_addr_q,
    input  logic [6:0]  mem_wr_addr_q,
    input  logic [6:0]  min_intv_q,
    input  logic        iteration_boundary_q,
    input  logic [63:0] reserved_token_x2_q,
    input  logic [31:0] reserved_mem_info_q,
    output logic [5:0]  status,
    output logic [8:0]  read_num,
    output logic [63:0] primary,
    output logic [6:0]  new_size,
    output logic [6:0]  new_last_size,
    output logic [6:0]  forward_size_n,
    output logic [6:0]  backward_i,
    output logic [6:0]  backward_j,
    output logic [6:0]  current_wr_addr,
    output logic [6:0]  current_rd_addr,
    output logic [6:0]  mem_wr_addr,
    output logic [6:0]  min_intv,
    output logic        iteration_boundary,
    output logic [63:0] last_token_x2,
    output logic [31:0] last_mem_info,
    output logic        done_valid,
    output logic [8:0]  done_read_num,
    output logic [6:0]  done_mem_size
);

    localparam int unsigned ST_W = 6;
    localparam int unsigned SZ_W = 7;

    localparam logic [ST_W-1:0] BCK_INI = 6'h4;
    localparam logic [ST_W-1:0] BCK_RUN = 6'h5;
    localparam logic [ST_W-1:0] BCK_END = 6'h6;
    localparam logic [ST_W-1:0] BUBBLE  = 6'h30;

    logic [5:0]  r_status,  w_status;
    logic [8:0]  r_read_num, w_read_num;
    logic [63:0] r_primary, w_primary;
    logic [6:0]  r_new_size, w_new_size;
    logic [6:0]  r_new_last_size, w_new_last_size;
    logic [6:0]  r_forward_size_n, w_forward_size_n;
    logic [6:0]  r_backward_i, w_backward_i;
    logic [6:0]  r_backward_j, w_backward_j;
    logic [6:0]  r_current_wr_addr, w_current_wr_addr;
    logic [6:0]  r_current_rd_addr, w_current_rd_addr;
    logic [6:0]  r_mem_wr_addr, w_mem_wr_addr;
    logic [6:0]  r_min_intv, w_min_intv;
    logic        r_iteration_boundary, w_iteration_boundary;
    logic [63:0] r_last_token_x2, w_last_token_x2;
    logic [31:0] r_last_mem_info, w_last_mem_info;
    logic        r_done_valid, w_done_valid;
    logic [8:0]  r_done_read_num, w_done_read_num;
    logic [6:0]  r_done_mem_size, w_done_mem_size;
    logic        w_j_bound;

    assign w_j_bound = (backward_j_q == SZ_W'(new_last_size_q - SZ_W'(1)));

    // Next-state decode: hold on stall, else pass through and apply the status branch.
    always_comb begin
        w_status             = r_status;
        w_read_num           = r_read_num;
        w_primary            = r_primary;
        w_new_size           = r_new_size;
        w_new_last_size      = r_new_last_size;
        w_forward_size_n     = r_forward_size_n;
        w_backward_i         = r_backward_i;
        w_backward_j         = r_backward_j;
        w_current_wr_addr    = r_current_wr_addr;
        w_current_rd_addr    = r_current_rd_addr;
        w_mem_wr_addr        = r_mem_wr_addr;
        w_min_intv           = r_min_intv;
        w_iteration_boundary = r_iteration_boundary;
        w_last_token_x2      = r_last_token_x2;
        w_last_mem_info      = r_last_mem_info;
        w_done_valid         = r_done_valid;
        w_done_read_num      = r_done_read_num;
        w_done_mem_size      = r_done_mem_size;
        if (!stall) begin
            w_status             = BCK_RUN;
            w_read_num           = read_num_q;
            w_primary            = primary_q;
            w_new_size           = new_size_q;
            w_new_last_size      = new_last_size_q;
            w_forward_size_n     = forward_size_n_q;
            w_backward_i         = backward_i_q;
            w_backward_j         = backward_j_q;
            w_current_wr_addr    = current_wr_addr_q;
            w_current_rd_addr    = current_rd_addr_q;
            w_mem_wr_addr        = mem_wr_addr_q;
            w_min_intv           = min_intv_q;
            w_iteration_boundary = iteration_boundary_q;
            w_last_token_x2      = reserved_token_x2_q;
            w_last_mem_info      = reserved_mem_info_q;
            w_done_valid         = 1'b0;
            case (status_q)
                BCK_INI: ;
                BCK_RUN: begin
                    if (!w_j_bound) begin
                        w_backward_j = SZ_W'(backward_j_q + SZ_W'(1));
                    end else if ((new_size_q == '0) || iteration_boundary_q) begin
                        w_status        = BCK_END;
                        w_done_valid    = 1'b1;
                        w_done_read_num = read_num_q;
                        w_done_mem_size = mem_wr_addr_q;
                    end else begin
                        w_backward_j         = '0;
                        w_new_last_size      = new_size_q;
                        w_new_size           = '0;
                        w_backward_i         = SZ_W'(backward_i_q - SZ_W'(1));
                        w_iteration_boundary = (backward_i_q == SZ_W'(1));
                        w_current_wr_addr    = SZ_W'(forward_size_n_q - SZ_W'(1));
                        w_current_rd_addr    = SZ_W'(forward_size_n_q - SZ_W'(1));
                        w_last_token_x2      = '0;
                    end
                end
                default: begin
                    w_status             = BUBBLE;
                    w_read_num           = '0;
                    w_primary            = '0;
                    w_new_size           = '0;
                    w_new_last_size      = '0;
                    w_forward_size_n     = '0;
                    w_backward_i         = '0;
                    w_backward_j         = '0;
                    w_current_wr_addr    = '0;
                    w_current_rd_addr    = '0;
                    w_mem_wr_addr        = '0;
                    w_min_intv           = '0;
                    w_iteration_boundary = 1'b0;
                    w_last_token_x2      = '0;
                    w_last_mem_info      = '0;
                    w_done_read_num      = '0;
                    w_done_mem_size      = '0;
                end
            endcase
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status             <= BUBBLE;
            r_read_num           <= '0;
            r_primary            <= '0;
            r_new_size           <= '0;
            r_new_last_size      <= '0;
            r_forward_size_n     <= '0;
            r_backward_i         <= '0;
            r_backward_j         <= '0;
            r_current_wr_addr    <= '0;
            r_current_rd_addr    <= '0;
            r_mem_wr_addr        <= '0;
            r_min_intv           <= '0;
            r_iteration_boundary <= 1'b0;
            r_last_token_x2      <= '0;
            r_last_mem_info      <= '0;
            r_done_valid         <= 1'b0;
            r_done_read_num      <= '0;
            r_done_mem_size      <= '0;
        end else begin
            r_status             <= w_status;
            r_read_num           <= w_read_num;
            r_primary            <= w_primary;
            r_new_size           <= w_new_size;
            r_new_last_size      <= w_new_last_size;
            r_forward_size_n     <= w_forward_size_n;
            r_backward_i         <= w_backward_i;
            r_backward_j         <= w_backward_j;
            r_current_wr_addr    <= w_current_wr_addr;
            r_current_rd_addr    <= w_current_rd_addr;
            r_mem_wr_addr        <= w_mem_wr_addr;
            r_min_intv           <= w_min_intv;
            r_iteration_boundary <= w_iteration_boundary;
            r_last_token_x2      <= w_last_token_x2;
            r_last_mem_info      <= w_last_mem_info;
            r_done_valid         <= w_done_valid;
            r_done_read_num      <= w_done_read_num;
            r_done_mem_size      <= w_done_mem_size;
        end
    end

    assign status             = r_status;
    assign read_num           = r_read_num;
    assign primary            = r_primary;
    assign new_size           = r_new_size;
    assign new_last_size      = r_new_last_size;
    assign forward_size_n     = r_forward_size_n;
    assign backward_i         = r_backward_i;
    assign backward_j         = r_backward_j;
    assign current_wr_addr    = r_current_wr_addr;
    assign current_rd_addr    = r_current_rd_addr;
    assign mem_wr_addr        = r_mem_wr_addr;
    assign min_intv           = r_min_intv;
    assign iteration_boundary = r_iteration_boundary;
    assign last_token_x2      = r_last_token_x2;
    assign last_mem_info      = r_last_mem_info;
    assign done_valid         = r_done_valid;
    assign done_read_num      = r_done_read_num;
    assign done_mem_size      = r_done_mem_size;

endmodule

// File: tb/tb_smem_bck_stage2.sv
// Randomized bench for smem_bck_stage2 against a per-branch behavioural model,
// plus directed loop / roll / termination / stall / init sequences.
module tb_smem_bck_stage2;

    localparam logic [5:0] BCK_INI = 6'h4;
    localparam logic [5:0] BCK_RUN = 6'h5;
    localparam logic [5:0] BCK_END = 6'h6;
    localparam logic [5:0] BUBBLE  = 6'h30;

    logic        clk, rst, stall;
    logic [5:0]  status_q;
    logic [8:0]  read_num_q;
    logic [63:0] primary_q, reserved_token_x2_q;
    logic [6:0]  new_size_q, new_last_size_q, forward_size_n_q, backward_i_q, backward_j_q;
    logic [6:0]  current_wr_addr_q, current_rd_addr_q, mem_wr_addr_q, min_intv_q;
    logic        iteration_boundary_q;
    logic [31:0] reserved_mem_info_q;

    logic [5:0]  status;
    logic [8:0]  read_num, done_read_num;
    logic [63:0] primary, last_token_x2;
    logic [6:0]  new_size, new_last_size, forward_size_n, backward_i, backward_j;
    logic [6:0]  current_wr_addr, current_rd_addr, mem_wr_addr, min_intv, done_mem_size;
    logic        iteration_boundary, done_valid;
    logic [31:0] last_mem_info;

    smem_bck_stage2 dut (
        .clk(clk), .rst(rst), .stall(stall),
        .status_q(status_q), .read_num_q(read_num_q), .primary_q(primary_q),
        .new_size_q(new_size_q), .new_last_size_q(new_last_size_q),
        .forward_size_n_q(forward_size_n_q), .backward_i_q(backward_i_q),
        .backward_j_q(backward_j_q), .current_wr_addr_q(current_wr_addr_q),
        .current_rd_addr_q(current_rd_addr_q), .mem_wr_addr_q(mem_wr_addr_q),
        .min_intv_q(min_intv_q), .iteration_boundary_q(iteration_boundary_q),
        .reserved_token_x2_q(reserved_token_x2_q), .reserved_mem_info_q(reserved_mem_info_q),
        .status(status), .read_num(read_num), .primary(primary), .new_size(new_size),
        .new_last_size(new_last_size), .forward_size_n(forward_size_n),
        .backward_i(backward_i), .backward_j(backward_j),
        .current_wr_addr(current_wr_addr), .current_rd_addr(current_rd_addr),
        .mem_wr_addr(mem_wr_addr), .min_intv(min_intv),
        .iteration_boundary(iteration_boundary), .last_token_x2(last_token_x2),
        .last_mem_info(last_mem_info), .done_valid(done_valid),
        .done_read_num(done_read_num), .done_mem_size(done_mem_size)
    );

    typedef struct packed {
        logic [5:0]  status;
        logic [8:0]  read_num;
        logic [63:0] primary;
        logic [6:0]  new_size, new_last_size, forward_size_n, backward_i, backward_j;
        logic [6:0]  current_wr_addr, current_rd_addr, mem_wr_addr, min_intv;
        logic        iteration_boundary;
        logic [63:0] last_token_x2;
        logic [31:0] last_mem_info;
        logic        done_valid;
        logic [8:0]  done_read_num;
        logic [6:0]  done_mem_size;
    } exp_t;

    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] wrap7(input int v);
        return 7'(((v % 128) + 128) % 128);
    endfunction

    // Everything copied from the current inputs; done report kept as is.
    function automatic exp_t pass_through(input exp_t prev);
        exp_t n = prev;
        n.status             = BCK_RUN;
        n.read_num           = read_num_q;
        n.primary            = primary_q;
        n.new_size           = new_size_q;
        n.new_last_size      = new_last_size_q;
        n.forward_size_n     = forward_size_n_q;
        n.backward_i         = backward_i_q;
        n.backward_j         = backward_j_q;
        n.current_wr_addr    = current_wr_addr_q;
        n.current_rd_addr    = current_rd_addr_q;
        n.mem_wr_addr        = mem_wr_addr_q;
        n.min_intv           = min_intv_q;
        n.iteration_boundary = iteration_boundary_q;
        n.last_token_x2      = reserved_token_x2_q;
        n.last_mem_info      = reserved_mem_info_q;
        n.done_valid         = 1'b0;
        return n;
    endfunction

    task automatic model_step();
        exp_t n = m;
        bit   at_bound;
        if (!rst) begin
            n = '0;
            n.status = BUBBLE;
        end else if (!stall) begin
            at_bound = ((int'(backward_j_q) + 1) % 128) == int'(new_last_size_q);
            if (status_q == BCK_INI) begin
                n = pass_through(m);
            end else if (status_q == BCK_RUN) begin
                n = pass_through(m);
                if (!at_bound) begin
                    n.backward_j = wrap7(int'(backward_j_q) + 1);
                end else if (new_size_q == 0 || iteration_boundary_q) begin
                    n.status        = BCK_END;
                    n.done_valid    = 1'b1;
                    n.done_read_num = read_num_q;
                    n.done_mem_size = mem_wr_addr_q;
                end else begin
                    n.backward_j         = 7'd0;
                    n.new_last_size      = new_size_q;
                    n.new_size           = 7'd0;
                    n.backward_i         = wrap7(int'(backward_i_q) - 1);
                    n.iteration_boundary = (backward_i_q == 7'd1);
                    n.current_wr_addr    = wrap7(int'(forward_size_n_q) - 1);
                    n.current_rd_addr    = wrap7(int'(forward_size_n_q) - 1);
                    n.last_token_x2      = 64'd0;
                end
            end else begin
                n = '0;
                n.status = BUBBLE;
            end
        end
        m = n;
    endtask

    task automatic check_all();
        chk("status", 64'(status), 64'(m.status));
        chk("read_num", 64'(read_num), 64'(m.read_num));
        chk("primary", primary, m.primary);
        chk("new_size", 64'(new_size), 64'(m.new_size));
        chk("new_last_size", 64'(new_last_size), 64'(m.new_last_size));
        chk("forward_size_n", 64'(forward_size_n), 64'(m.forward_size_n));
        chk("backward_i", 64'(backward_i), 64'(m.backward_i));
        chk("backward_j", 64'(backward_j), 64'(m.backward_j));
        chk("current_wr_addr", 64'(current_wr_addr), 64'(m.current_wr_addr));
        chk("current_rd_addr", 64'(current_rd_addr), 64'(m.current_rd_addr));
        chk("mem_wr_addr", 64'(mem_wr_addr), 64'(m.mem_wr_addr));
        chk("min_intv", 64'(min_intv), 64'(m.min_intv));
        chk("iteration_boundary", 64'(iteration_boundary), 64'(m.iteration_boundary));
        chk("last_token_x2", last_token_x2, m.last_token_x2);
        chk("last_mem_info", 64'(last_mem_info), 64'(m.last_mem_info));
        chk("done_valid", 64'(done_valid), 64'(m.done_valid));
        if (m.done_valid) begin
            chk("done_read_num", 64'(done_read_num), 64'(m.done_read_num));
            chk("done_mem_size", 64'(done_mem_size), 64'(m.done_mem_size));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic rand_inputs();
        int sel = $urandom_range(0, 9);
        case (sel)
            0:             status_q = BCK_INI;
            1, 2, 3, 4, 5: status_q = BCK_RUN;
            6:             status_q = BCK_END;
            7:             status_q = BUBBLE;
            default:       status_q = 6'($urandom);
        endcase
        read_num_q           = 9'($urandom);
        primary_q            = {$urandom, $urandom};
        new_size_q           = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 8));
        new_last_size_q      = ($urandom_range(0, 30) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
        backward_j_q         = ($urandom_range(0, 30) == 0) ? 7'd127 : 7'($urandom_range(0, 6));
        backward_i_q         = 7'($urandom_range(0, 8));
        forward_size_n_q     = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
        current_wr_addr_q    = 7'($urandom);
        current_rd_addr_q    = 7'($urandom);
        mem_wr_addr_q        = 7'($urandom);
        min_intv_q           = 7'($urandom);
        iteration_boundary_q = ($urandom_range(0, 4) == 0);
        reserved_token_x2_q  = {$urandom, $urandom};
        reserved_mem_info_q  = $urandom;
    endtask

    initial begin
        m = '0;
        rst = 1'b0;
        stall = 1'b0;
        rand_inputs();

        // Reset with random inputs for two cycles
        step();
        rand_inputs();
        step();
        chk("rst_status", 64'(status), 64'(BUBBLE));
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_primary", primary, 64'd0);

        // Inner loop j = 0,1,2 with new_last_size 4
        rst = 1'b1;
        rand_inputs();
        status_q = BCK_RUN;
        new_last_size_q = 7'd4;
        for (int j = 0; j < 3; j++) begin
            backward_j_q = 7'(j);
            step();
            chk("inner_j", 64'(backward_j), 64'(j + 1));
            chk("inner_status", 64'(status), 64'(BCK_RUN));
            chk("inner_done", 64'(done_valid), 64'd0);
        end

        // Iteration roll
        backward_j_q = 7'd3;
        new_size_q = 7'd2;
        backward_i_q = 7'd5;
        forward_size_n_q = 7'd10;
        iteration_boundary_q = 1'b0;
        step();
        chk("roll_nls", 64'(new_last_size), 64'd2);
        chk("roll_ns", 64'(new_size), 64'd0);
        chk("roll_i", 64'(backward_i), 64'd4);
        chk("roll_j", 64'(backward_j), 64'd0);
        chk("roll_rd", 64'(current_rd_addr), 64'd9);
        chk("roll_ib", 64'(iteration_boundary), 64'd0);

        // Termination
        new_size_q = 7'd0;
        mem_wr_addr_q = 7'd3;
        read_num_q = 9'd17;
        step();
        chk("end_status", 64'(status), 64'(BCK_END));
        chk("end_dv", 64'(done_valid), 64'd1);
        chk("end_rn", 64'(done_read_num), 64'd17);
        chk("end_ms", 64'(done_mem_size), 64'd3);

        // Stall holds the done report for three cycles
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            step();
            chk("stall_dv", 64'(done_valid), 64'd1);
            chk("stall_rn", 64'(done_read_num), 64'd17);
        end
        stall = 1'b0;
        status_q = BUBBLE;
        step();
        chk("unstall_dv", 64'(done_valid), 64'd0);

        // Init then bubble
        rand_inputs();
        status_q = BCK_INI;
        backward_i_q = 7'd6;
        step();
        chk("ini_status", 64'(status), 64'(BCK_RUN));
        chk("ini_i", 64'(backward_i), 64'd6);
        status_q = BUBBLE;
        step();
        chk("bub_status", 64'(status), 64'(BUBBLE));
        chk("bub_i", 64'(backward_i), 64'd0);
        chk("bub_primary", primary, 64'd0);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            stall = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 40) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
